response_bus_arbiter: RTL and testbench
=======================================

# response_bus_arbiter

Round-robin arbiter for the shared response bus. Every slave that returns data (on-chip RAM, peripherals) raises `response_breq`, waits for a one-cycle `response_bgnt`, then drives the bus while asserting `response_bhold`. The block serialises ownership, publishes the current owner index for the response-data/tag/oe mux, and releases a stuck owner with a hold watchdog.

## Interface
- `N_SLAVES`, default 4: number of requesting slaves, legal range 2..16.
- `MAX_HOLD`, default 16: the longest continuous `bhold` run allowed, in cycles. Legal range 1..255.
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `breq`  in  N_SLAVES  per-slave bus request, level. A slave holds it until it sees its grant.
- `bhold`  in  N_SLAVES  per-slave hold, asserted while the owner drives the bus.
- `bgnt`  out  N_SLAVES  one-hot grant pulse, registered, one cycle.
- `bus_busy`  out  1  state is not IDLE.
- `bus_owner`  out  $clog2(N_SLAVES)  index of the current or most recent grantee; selects the response mux.
- `owner_valid`  out  1  high in BUSY only, when the owner may drive.
- `timeout`  out  1  sticky flag: the watchdog forced a release.
- `timeout_clear`  in  1  synchronous clear of `timeout`.

## Operation
- Reset (async, `reset_n`=0):
  - state=IDLE, `bgnt`=0, `bus_owner`=0, `owner_valid`=0, `timeout`=0, `hold_cnt`=0.
  - Priority pointer = N_SLAVES-1, so slave 0 wins first.
- FSM states: IDLE, GRANT, BUSY.
- IDLE:
  - If any `breq` is set, pick a winner w by round-robin. The search starts at pointer+1 and wraps modulo N_SLAVES.
  - Register `bgnt[w]`=1, `bus_owner`=w, pointer=w, and go to GRANT.
- GRANT: lasts one cycle, with `bgnt[w]` high. Then go to BUSY unconditionally and load `hold_cnt`=0.
- BUSY:
  - `owner_valid`=1.
  - If `bhold[bus_owner]`=1 and `hold_cnt` < MAX_HOLD: stay in BUSY and increment `hold_cnt`.
  - If `bhold[bus_owner]`=0, the owner releases. In the same cycle, arbitrate over `breq` as in IDLE:
    - if there is a winner, go to GRANT with the new grant registered;
    - otherwise go to IDLE.
  - If `bhold[bus_owner]`=1 and `hold_cnt`=MAX_HOLD: force release, set `timeout`=1, and arbitrate as on a normal release.
- `bhold` from non-owners is ignored.
- A `breq` from the current owner during BUSY competes normally. Because round-robin places the owner last, another requester wins first.
- `timeout_clear` and a new timeout in the same cycle: the set wins.
- A slave that drops `breq` before its grant is still granted. Its BUSY ends in the first cycle that `bhold` is low, which is legal.

## Timing
- Grant latency: `breq` first high in cycle t while IDLE gives `bgnt` high in cycle t+1.
- The owner drives the bus with `bhold` high from cycle t+2.
- Single-beat slave (hold for one cycle):
  - t+1 GRANT, t+2 BUSY with hold, t+3 BUSY with release.
  - The next `bgnt` comes at t+4, so grants are spaced 3 cycles apart.
- `bgnt`, `bus_owner`, `owner_valid`, `bus_busy` and `timeout` are all registered outputs. None has a combinational path from the inputs.
- `hold_cnt` is 8 bits and saturates. The forced release happens on the edge after MAX_HOLD+1 consecutive hold cycles.
- If `reset_n` is asserted mid-BUSY, all outputs return to reset values immediately. The slave's own reset clears its hold.

## Structure
- Shared in `bus_package`:
  - `RESPONSE_SLAVES` constant, the default for N_SLAVES;
  - `OWNER_WIDTH` = $clog2(RESPONSE_SLAVES).
- The FSM enum is local to the module.
- One sub-module, `rr_priority_picker`: purely combinational.
  - Inputs: request vector and pointer.
  - Outputs: winner index and a found flag.
  - It is reused by both the IDLE and BUSY arbitration paths.

## Test plan
- Reset, then `breq`=0001 at cycle 1 -> `bgnt`=0001 at cycle 2; `owner_valid`=1 at cycle 3; after `bhold[0]` pulses for one cycle, state is IDLE at cycle 5.
- `breq`=1111 held, each slave holds for one cycle -> grants in order 0,1,2,3,0, spaced 3 cycles apart, and `bus_owner` tracks each grant.
- Owner 2 releases while `breq`=0110 -> next `bgnt`=0100 is not issued; `bgnt`=0010 is issued on the following cycle, so the owner is placed last.
- `bhold[1]` stuck high, MAX_HOLD=4 -> forced release after 5 hold cycles and `timeout`=1; `timeout_clear` returns it to 0.
- `reset_n` low mid-BUSY -> `bgnt`=0, `owner_valid`=0 and `bus_owner`=0 asynchronously; after reset, slave 0 wins first again.
- `bhold` from a non-owner (slave 3 while slave 1 owns) -> ignored; slave 1's release ends BUSY.

Source files
------------

// File: rtl/bus_package.sv
// Shared constants for the response bus: default slave count and owner index width.
package bus_package;

    localparam int unsigned RESPONSE_SLAVES = 4;
    localparam int unsigned OWNER_WIDTH     = $clog2(RESPONSE_SLAVES);
    localparam int unsigned HOLD_CNT_WIDTH  = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first set request after ptr, wrapping modulo N_SLAVES.
module rr_priority_picker import bus_package::*; #(
    parameter  int unsigned N_SLAVES = RESPONSE_SLAVES,
    localparam int unsigned OwnerW   = $clog2(N_SLAVES)
) (
    input  logic [N_SLAVES-1:0] req,
    input  logic [OwnerW-1:0]   ptr,
    output logic [OwnerW-1:0]   winner,
    output logic                found
);

    logic [OwnerW-1:0] idx;

    // Offsets 1..N put the previous winner (ptr) last in line.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= N_SLAVES; i++) begin
            idx = OwnerW'((32'(ptr) + i) % N_SLAVES);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/response_bus_arbiter.sv
// Round-robin owner arbitration for the shared response bus with a hold watchdog.
module response_bus_arbiter import bus_package::*; #(
    parameter  int unsigned N_SLAVES = RESPONSE_SLAVES,
    parameter  int unsigned MAX_HOLD = 16,
    localparam int unsigned OwnerW   = (N_SLAVES == RESPONSE_SLAVES) ? OWNER_WIDTH
                                                                     : $clog2(N_SLAVES)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [N_SLAVES-1:0] breq,
    input  logic [N_SLAVES-1:0] bhold,
    input  logic                timeout_clear,
    output logic [N_SLAVES-1:0] bgnt,
    output logic                bus_busy,
    output logic [OwnerW-1:0]   bus_owner,
    output logic                owner_valid,
    output logic                timeout
);

    typedef enum logic [1:0] {StIdle, StGrant, StBusy} state_e;

    localparam logic [HOLD_CNT_WIDTH-1:0] MaxHoldCnt = HOLD_CNT_WIDTH'(MAX_HOLD);

    state_e                    state_q;
    logic [N_SLAVES-1:0]       bgnt_q;
    logic                      busy_q;
    logic [OwnerW-1:0]         owner_q;
    logic [OwnerW-1:0]         ptr_q;
    logic                      valid_q;
    logic                      timeout_q;
    logic [HOLD_CNT_WIDTH-1:0] hold_cnt_q;

    logic [OwnerW-1:0]   pick_winner;
    logic                pick_found;
    logic [N_SLAVES-1:0] grant_vec;
    logic                owner_hold;

    // One picker serves both the idle and the release-time arbitration.
    rr_priority_picker #(
        .N_SLAVES (N_SLAVES)
    ) u_picker (
        .req    (breq),
        .ptr    (ptr_q),
        .winner (pick_winner),
        .found  (pick_found)
    );

    assign grant_vec  = N_SLAVES'(1) << pick_winner;
    assign owner_hold = bhold[owner_q];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            bgnt_q     <= '0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            ptr_q      <= OwnerW'(N_SLAVES - 1);
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            // A watchdog set further down overrides this clear.
            if (timeout_clear) begin
                timeout_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (pick_found) begin
                        state_q <= StGrant;
                        bgnt_q  <= grant_vec;
                        owner_q <= pick_winner;
                        ptr_q   <= pick_winner;
                        busy_q  <= 1'b1;
                    end
                end
                StGrant: begin
                    state_q    <= StBusy;
                    bgnt_q     <= '0;
                    hold_cnt_q <= '0;
                    valid_q    <= 1'b1;
                end
                StBusy: begin
                    if (owner_hold && (hold_cnt_q < MaxHoldCnt)) begin
                        if (hold_cnt_q != '1) begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end else begin
                        if (owner_hold) begin
                            timeout_q <= 1'b1;
                        end
                        valid_q <= 1'b0;
                        if (pick_found) begin
                            state_q <= StGrant;
                            bgnt_q  <= grant_vec;
                            owner_q <= pick_winner;
                            ptr_q   <= pick_winner;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    bgnt_q  <= '0;
                end
            endcase
        end
    end

    assign bgnt        = bgnt_q;
    assign bus_busy    = busy_q;
    assign bus_owner   = owner_q;
    assign owner_valid = valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_response_bus_arbiter.sv
// Bench for response_bus_arbiter: vector table, corner-case sequences, random vs reference model.
module tb_response_bus_arbiter;

    localparam int N  = 4;
    localparam int MH = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] breq = '0;
    logic [3:0] bhold = '0;
    logic       timeout_clear = 1'b0;
    logic [3:0] bgnt;
    logic       bus_busy;
    logic [1:0] bus_owner;
    logic       owner_valid;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    response_bus_arbiter #(
        .N_SLAVES (N),
        .MAX_HOLD (MH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .breq          (breq),
        .bhold         (bhold),
        .timeout_clear (timeout_clear),
        .bgnt          (bgnt),
        .bus_busy      (bus_busy),
        .bus_owner     (bus_owner),
        .owner_valid   (owner_valid),
        .timeout       (timeout)
    );

    typedef struct {
        logic [3:0] rq;
        logic [3:0] hd;
        logic       clr;
        logic [3:0] eg;
        logic       eb;
        logic [1:0] eo;
        logic       ev;
        logic       et;
    } vec_t;

    vec_t tbl[13];

    // Reference model: timestamps and a tenure flag, round robin by distance from last winner.
    int m_now, m_active, m_grant_time, m_owner, m_ptr, m_run, m_to;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [3:0] eg, input logic eb,
                              input logic [1:0] eo, input logic ev, input logic et);
        check({tag, ".bgnt"}, 32'(bgnt), 32'(eg));
        check({tag, ".bus_busy"}, 32'(bus_busy), 32'(eb));
        check({tag, ".bus_owner"}, 32'(bus_owner), 32'(eo));
        check({tag, ".owner_valid"}, 32'(owner_valid), 32'(ev));
        check({tag, ".timeout"}, 32'(timeout), 32'(et));
    endtask

    function automatic int rr_pick(input logic [3:0] req, input int ptr);
        int best = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                int d = (i - ptr - 1 + 2 * N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_now = 0; m_active = 0; m_grant_time = -10;
        m_owner = 0; m_ptr = N - 1; m_run = 0; m_to = 0;
    endtask

    task automatic model_step();
        bit arb = 0;
        bit set_to = 0;
        int w;
        if (m_active == 0) begin
            arb = 1;
        end else if (m_now > m_grant_time) begin
            if (bhold[m_owner] && m_run < MH) begin
                m_run++;
            end else begin
                set_to = bhold[m_owner];
                m_active = 0;
                arb = 1;
            end
        end
        if (timeout_clear) m_to = 0;
        if (set_to) m_to = 1;
        if (arb) begin
            w = rr_pick(breq, m_ptr);
            if (w >= 0) begin
                m_active = 1; m_grant_time = m_now + 1;
                m_owner = w; m_ptr = w; m_run = 0;
            end
        end
        m_now++;
    endtask

    task automatic model_check(input string tag);
        logic [3:0] one = 4'b0001;
        logic [3:0] eg;
        eg = (m_active != 0 && m_now == m_grant_time) ? (one << m_owner) : 4'b0000;
        check_outs(tag, eg, m_active != 0, 2'(m_owner),
                   m_active != 0 && m_now > m_grant_time, m_to != 0);
    endtask

    task automatic cycle(input logic [3:0] rq, input logic [3:0] hd, input logic clr);
        breq = rq; bhold = hd; timeout_clear = clr;
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; breq = '0; bhold = '0; timeout_clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic hold_run(input logic clr_at_end);
        cycle(4'b0010, 4'b0000, 1'b0);
        check("to.grant", 32'(bgnt), 32'h2);
        cycle(4'b0000, 4'b0010, 1'b0);
        check("to.busy", 32'(owner_valid), 32'h1);
        for (int k = 0; k < MH; k++) begin
            cycle(4'b0000, 4'b0010, 1'b0);
            check("to.still_busy", 32'(owner_valid), 32'h1);
        end
        cycle(4'b0000, 4'b0010, clr_at_end);
        check("to.released", 32'(bus_busy), 32'h0);
        check("to.flag", 32'(timeout), 32'h1);
    endtask

    initial begin
        int gidx[$];
        int gtime[$];
        logic [3:0] h1, h2;
        int p;

        //            rq       hd       clr   eg       eb    eo    ev    et
        tbl[0]  = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[3]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[4]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[5]  = '{4'b0000, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[6]  = '{4'b0000, 4'b1010, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[7]  = '{4'b0000, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0};
        tbl[8]  = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0};
        tbl[9]  = '{4'b0000, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0};
        tbl[10] = '{4'b0110, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b0};
        tbl[11] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0};
        tbl[12] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0};

        do_reset();
        check_outs("reset", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].rq, tbl[i].hd, tbl[i].clr);
            check_outs($sformatf("vec%0d", i), tbl[i].eg, tbl[i].eb, tbl[i].eo, tbl[i].ev,
                       tbl[i].et);
        end

        // All four requesting, each owner holds exactly one cycle.
        do_reset();
        h1 = '0; h2 = '0;
        for (int c = 0; c < 20; c++) begin
            cycle(4'hF, h2, 1'b0);
            h2 = h1;
            h1 = bgnt;
            if (bgnt != 4'b0000) begin
                for (int b = 0; b < N; b++) begin
                    if (bgnt[b]) begin
                        gidx.push_back(b);
                        gtime.push_back(c);
                        check("rr.owner", 32'(bus_owner), 32'(b));
                    end
                end
            end
        end
        check("rr.count_ok", 32'(gidx.size() >= 5), 32'h1);
        for (int g = 0; g < 5 && g < gidx.size(); g++) begin
            check($sformatf("rr.order%0d", g), 32'(gidx[g]), 32'(g % N));
            if (g > 0) check($sformatf("rr.spacing%0d", g), 32'(gtime[g] - gtime[g-1]), 32'd3);
        end

        // Watchdog, clear, then a clear colliding with a new timeout.
        do_reset();
        hold_run(1'b0);
        cycle(4'b0000, 4'b0000, 1'b1);
        check("to.cleared", 32'(timeout), 32'h0);
        hold_run(1'b1);
        cycle(4'b0000, 4'b0000, 1'b0);
        check("to.sticky", 32'(timeout), 32'h1);
        cycle(4'b0000, 4'b0000, 1'b1);

        // Asynchronous reset in the middle of a tenure.
        do_reset();
        cycle(4'b0100, 4'b0000, 1'b0);
        cycle(4'b0000, 4'b0100, 1'b0);
        check("ar.busy_owner", 32'(bus_owner), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("ar.async", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        model_reset();
        cycle(4'hF, 4'b0000, 1'b0);
        check("ar.first_winner", 32'(bgnt), 32'h1);

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            p = (c < 1500) ? 85 : 40;
            cycle(4'($urandom),
                  ($urandom_range(0, 99) < p) ? 4'hF : 4'($urandom),
                  $urandom_range(0, 15) == 0);
            model_check("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
